// File: rtl/axi_riscv_lrsc_pkg.sv
// axi_riscv_lrsc_pkg: shared constants and tag extraction for the LR/SC reservation logic.
package axi_riscv_lrsc_pkg;
  localparam int unsigned TIMEOUT_DISABLED = 0;
  localparam int unsigned MAX_ADDR_WIDTH = 128;
  function automatic logic [MAX_ADDR_WIDTH-1:0] addr_tag(input logic [MAX_ADDR_WIDTH-1:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction
endpackage

// File: rtl/lzc.sv
// lzc: trailing (MODE=0) or leading (MODE=1) zero counter with an all-zero flag.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit MODE = 1'b0,
  localparam int unsigned CNT_WIDTH = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (!MODE && in_i[i]) cnt_o = CNT_WIDTH'(i);
    for (int i = 0; i < WIDTH; i++) if (MODE && in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/axi_riscv_lrsc_rsv_table.sv
// axi_riscv_lrsc_rsv_table: LR/SC reservation table with id-keyed slots, age-based eviction,
// write snooping and optional reservation timeout.
module axi_riscv_lrsc_rsv_table
  import axi_riscv_lrsc_pkg::*;
#(
  parameter int unsigned NUM_RSV        = 4,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ADDR_LSB       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned CNT_W         = $clog2(NUM_RSV + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lr_valid_i,
  output logic                  lr_ready_o,
  input  logic [ID_WIDTH-1:0]   lr_id_i,
  input  logic [ADDR_WIDTH-1:0] lr_addr_i,
  input  logic                  sc_valid_i,
  output logic                  sc_ready_o,
  input  logic [ID_WIDTH-1:0]   sc_id_i,
  input  logic [ADDR_WIDTH-1:0] sc_addr_i,
  output logic                  sc_rsp_valid_o,
  output logic                  sc_rsp_ok_o,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  output logic [CNT_W-1:0]      rsv_count_o
);
  localparam int unsigned IDX_W = NUM_RSV > 1 ? $clog2(NUM_RSV) : 1;
  localparam int unsigned TAG_W = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned TMR_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    age;
    logic [TMR_W-1:0]    timer;
  } slot_t;
  slot_t [NUM_RSV-1:0] slots_q, slots_d;
  logic [TAG_W-1:0] lr_tag, sc_tag, wr_tag;
  logic [NUM_RSV-1:0] free_vec;
  logic [IDX_W-1:0] free_idx, id_idx, evict_idx, evict_age, lr_idx;
  logic free_none, id_hit, sc_hit, sc_ok;
  logic [CNT_W-1:0] cnt_d;
  assign lr_tag = TAG_W'(addr_tag(MAX_ADDR_WIDTH'(lr_addr_i), ADDR_LSB));
  assign sc_tag = TAG_W'(addr_tag(MAX_ADDR_WIDTH'(sc_addr_i), ADDR_LSB));
  assign wr_tag = TAG_W'(addr_tag(MAX_ADDR_WIDTH'(wr_addr_i), ADDR_LSB));
  assign sc_ready_o = 1'b1;
  assign lr_ready_o = !sc_valid_i;
  always_comb for (int i = 0; i < NUM_RSV; i++) free_vec[i] = !slots_q[i].valid;
  lzc #(.WIDTH(NUM_RSV), .MODE(1'b0)) i_free_lzc (
    .in_i   (free_vec),
    .cnt_o  (free_idx),
    .empty_o(free_none)
  );
  always_comb begin
    id_hit = 1'b0;
    id_idx = '0;
    sc_hit = 1'b0;
    evict_idx = '0;
    evict_age = '0;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (!id_hit && slots_q[i].valid && slots_q[i].id == lr_id_i) begin
        id_hit = 1'b1;
        id_idx = IDX_W'(i);
      end
      if (slots_q[i].age > evict_age) begin
        evict_age = slots_q[i].age;
        evict_idx = IDX_W'(i);
      end
      sc_hit = sc_hit | (slots_q[i].valid && slots_q[i].id == sc_id_i && slots_q[i].tag == sc_tag);
    end
    lr_idx = id_hit ? id_idx : free_none ? evict_idx : free_idx;
    sc_ok = sc_hit && !(wr_valid_i && wr_tag == sc_tag);
  end
  // Invalidations (timeout, write, SC) are applied before an LR install so a same-cycle LR survives.
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (TIMEOUT_CYCLES != TIMEOUT_DISABLED && slots_q[i].valid) begin
        slots_d[i].timer = slots_q[i].timer + 1'b1;
        if (slots_q[i].timer == TMR_W'(TIMEOUT_CYCLES - 1)) slots_d[i].valid = 1'b0;
      end
      if (wr_valid_i && slots_q[i].tag == wr_tag) slots_d[i].valid = 1'b0;
      if (sc_valid_i && (slots_q[i].id == sc_id_i || (sc_ok && slots_q[i].tag == sc_tag))) slots_d[i].valid = 1'b0;
    end
    if (lr_valid_i && lr_ready_o) begin
      for (int i = 0; i < NUM_RSV; i++)
        if (slots_d[i].valid && slots_d[i].age != '1) slots_d[i].age = slots_d[i].age + 1'b1;
      slots_d[lr_idx] = '{valid: 1'b1, id: lr_id_i, tag: lr_tag, age: '0, timer: '0};
    end
    cnt_d = '0;
    for (int i = 0; i < NUM_RSV; i++) cnt_d = cnt_d + CNT_W'(slots_d[i].valid);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slots_q <= '0;
      sc_rsp_valid_o <= 1'b0;
      sc_rsp_ok_o <= 1'b0;
      rsv_count_o <= '0;
    end else begin
      slots_q <= slots_d;
      sc_rsp_valid_o <= sc_valid_i;
      sc_rsp_ok_o <= sc_valid_i && sc_ok;
      rsv_count_o <= cnt_d;
    end
  end
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) NUM_RSV >= 1 && ADDR_LSB < ADDR_WIDTH && ADDR_WIDTH <= MAX_ADDR_WIDTH);
`endif
endmodule

// File: tb/tb_axi_riscv_lrsc_rsv_table.sv
// tb_axi_riscv_lrsc_rsv_table: scenario tasks with a response scoreboard for the reservation table.
module tb_axi_riscv_lrsc_rsv_table;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lr_valid = 1'b0, sc_valid = 1'b0, wr_valid = 1'b0;
  logic [3:0] lr_id = '0, sc_id = '0;
  logic [63:0] lr_addr = '0, sc_addr = '0, wr_addr = '0;
  logic lr_ready, sc_ready, rsp_valid, rsp_ok;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit exp_q[$];
  bit sc_sent = 1'b0;
  always #5 clk = ~clk;
  axi_riscv_lrsc_rsv_table #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lr_valid_i(lr_valid), .lr_ready_o(lr_ready), .lr_id_i(lr_id), .lr_addr_i(lr_addr),
    .sc_valid_i(sc_valid), .sc_ready_o(sc_ready), .sc_id_i(sc_id), .sc_addr_i(sc_addr),
    .sc_rsp_valid_o(rsp_valid), .sc_rsp_ok_o(rsp_ok),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .rsv_count_o(count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected valid=1 ok=%0b, no response required", rsp_ok);
      end else begin
        bit e = exp_q.pop_front();
        if (rsp_ok !== e) begin
          errors++;
          $display("FAIL rsp_ok got=%0b exp=%0b at %0t", rsp_ok, e, $time);
        end
      end
    end else if (sc_sent) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing valid=0 exp=1 at %0t", $time);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (rsp_ok !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rsp_ok_idle got=%0b exp=0", rsp_ok);
    end
    sc_sent = 1'b0;
  endtask
  task automatic lr(input logic [3:0] id, input logic [63:0] a);
    lr_valid = 1'b1; lr_id = id; lr_addr = a;
    tick();
    lr_valid = 1'b0;
  endtask
  task automatic sc(input logic [3:0] id, input logic [63:0] a, input bit e);
    sc_valid = 1'b1; sc_id = id; sc_addr = a;
    exp_q.push_back(e);
    sc_sent = 1'b1;
    tick();
    sc_valid = 1'b0;
  endtask
  task automatic wr(input logic [63:0] a);
    wr_valid = 1'b1; wr_addr = a;
    tick();
    wr_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic test_reset();
    sc_valid = 1'b1;
    #2;
    checks++; if (lr_ready !== 1'b0) begin errors++; $display("FAIL rst_lr_ready_sc got=%0b exp=0", lr_ready); end
    sc_valid = 1'b0;
    #2;
    checks++; if (lr_ready !== 1'b1) begin errors++; $display("FAIL rst_lr_ready got=%0b exp=1", lr_ready); end
    checks++; if (sc_ready !== 1'b1) begin errors++; $display("FAIL rst_sc_ready got=%0b exp=1", sc_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (rsp_valid !== 1'b0 || rsp_ok !== 1'b0) begin errors++; $display("FAIL rst_rsp got=%0b%0b exp=00", rsp_valid, rsp_ok); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    lr(4'd1, 64'h1000);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    sc(4'd1, 64'h1004, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
  endtask
  task automatic test_write();
    lr(4'd1, 64'h1000);
    wr(64'h1000);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wr_clear_count got=%0d exp=0", count); end
    sc(4'd1, 64'h1000, 1'b0);
    lr(4'd1, 64'h1000);
    wr_valid = 1'b1; wr_addr = 64'h1000;
    sc(4'd1, 64'h1000, 1'b0);
    wr_valid = 1'b0;
    lr(4'd3, 64'h2000);
    wr(64'h2008);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wr_other_tag_count got=%0d exp=1", count); end
    sc(4'd3, 64'h2007, 1'b1);
  endtask
  task automatic test_lr_wr_same_cycle();
    wr_valid = 1'b1; wr_addr = 64'h3000;
    lr(4'd4, 64'h3000);
    wr_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL lr_wr_count got=%0d exp=1", count); end
    sc(4'd4, 64'h3000, 1'b1);
  endtask
  task automatic test_reuse_id();
    lr(4'd6, 64'h100);
    lr(4'd6, 64'h200);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL reuse_count got=%0d exp=1", count); end
    sc(4'd6, 64'h100, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reuse_clear got=%0d exp=0", count); end
  endtask
  task automatic test_same_tag();
    lr(4'd1, 64'h80);
    lr(4'd2, 64'h80);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL tag_count2 got=%0d exp=2", count); end
    sc(4'd1, 64'h80, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL tag_count0 got=%0d exp=0", count); end
    sc(4'd2, 64'h80, 1'b0);
  endtask
  task automatic test_priority();
    sc_valid = 1'b1; sc_id = 4'd5; sc_addr = 64'h300;
    lr_valid = 1'b1; lr_id = 4'd5; lr_addr = 64'h300;
    #1;
    checks++; if (lr_ready !== 1'b0) begin errors++; $display("FAIL prio_lr_ready got=%0b exp=0", lr_ready); end
    exp_q.push_back(1'b0);
    sc_sent = 1'b1;
    tick();
    sc_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL prio_lr_held got=%0d exp=0", count); end
    #1;
    checks++; if (lr_ready !== 1'b1) begin errors++; $display("FAIL prio_lr_ready1 got=%0b exp=1", lr_ready); end
    tick();
    lr_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL prio_lr_taken got=%0d exp=1", count); end
    sc(4'd5, 64'h300, 1'b1);
  endtask
  task automatic test_evict();
    for (int i = 0; i < 5; i++) begin
      lr(4'(i), 64'(i * 8));
      checks++;
      if (count !== 3'(i < 4 ? i + 1 : 4)) begin errors++; $display("FAIL evict_count%0d got=%0d exp=%0d", i, count, i < 4 ? i + 1 : 4); end
    end
    sc(4'd0, 64'h0, 1'b0);
    sc(4'd4, 64'h20, 1'b1);
    sc(4'd1, 64'h8, 1'b1);
    sc(4'd2, 64'h10, 1'b1);
    sc(4'd3, 64'h18, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL evict_drain got=%0d exp=0", count); end
  endtask
  task automatic test_timeout();
    lr(4'd2, 64'h40);
    idle(7);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL to_alive got=%0d exp=1", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL to_expired got=%0d exp=0", count); end
    tick();
    sc(4'd2, 64'h40, 1'b0);
    lr(4'd2, 64'h40);
    idle(4);
    sc(4'd2, 64'h40, 1'b1);
    lr(4'd2, 64'h40);
    idle(6);
    sc(4'd2, 64'h40, 1'b1);
  endtask
  task automatic test_reset_mid();
    lr(4'd7, 64'h500);
    sc_valid = 1'b1; sc_id = 4'd7; sc_addr = 64'h500;
    rst_n = 1'b0;
    tick();
    sc_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rstmid_state got=%0b/%0d exp=0/0", rsp_valid, count); end
    rst_n = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got=%0b exp=0", rsp_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_write();
    test_lr_wr_same_cycle();
    test_reuse_id();
    test_same_tag();
    test_priority();
    test_evict();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
